apb_requester: RTL and testbench

//  APB initiator: the CPU-facing end of the system APB. Takes one load/store

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_lane_align.sv | 50 +++++
 rtl/apb_requester.sv | 174 +++++++++++++++++
 tb/tb_apb_requester.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: access size encodings and requester state encoding.
// Used by the requester, the address decoder and the bench.
package apb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane steering for the APB requester: write strobes/replicated data,
// read extraction with sign/zero extension, and misalignment detection.
module apb_lane_align
    import apb_pkg::*;
(
    input  logic [1:0]  wr_off_i,
    input  logic [1:0]  wr_size_i,
    input  logic [31:0] wr_data_i,
    output logic        misaligned_o,
    output logic [3:0]  wr_strb_o,
    output logic [31:0] wr_data_o,
    input  logic [1:0]  rd_off_i,
    input  logic [1:0]  rd_size_i,
    input  logic        rd_signed_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] rd_data_o
);

    logic [31:0] rd_shifted;

    always_comb begin
        misaligned_o = ((wr_size_i == SZ_HALF) && wr_off_i[0])
                    || ((wr_size_i == SZ_WORD) && (wr_off_i != 2'd0))
                    || (wr_size_i == 2'd3);
        case (wr_size_i)
            SZ_BYTE: begin
                wr_strb_o = 4'b0001 << wr_off_i;
                wr_data_o = {4{wr_data_i[7:0]}};
            end
            SZ_HALF: begin
                wr_strb_o = 4'b0011 << wr_off_i;
                wr_data_o = {2{wr_data_i[15:0]}};
            end
            default: begin
                wr_strb_o = 4'hF;
                wr_data_o = wr_data_i;
            end
        endcase
    end

    always_comb begin
        rd_shifted = rd_data_i >> {rd_off_i, 3'b000};
        case (rd_size_i)
            SZ_BYTE: rd_data_o = {{24{rd_signed_i & rd_shifted[7]}}, rd_shifted[7:0]};
            SZ_HALF: rd_data_o = {{16{rd_signed_i & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_data_o = rd_shifted;
        endcase
    end

endmodule

// File: rtl/apb_requester.sv
// APB initiator: accepts one core load/store at a time, runs SETUP/ACCESS,
// and returns aligned read data or an error (misalignment, perr, timeout).
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic                  pready,
    input  logic                  perr
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic [3:0]            pstb_q, pstb_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic        misaligned;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        timeout_hit;

    apb_lane_align u_lane_align (
        .wr_off_i    (req_addr[1:0]),
        .wr_size_i   (req_size),
        .wr_data_i   (req_wdata),
        .misaligned_o(misaligned),
        .wr_strb_o   (wr_strb),
        .wr_data_o   (wr_data),
        .rd_off_i    (paddr_q[1:0]),
        .rd_size_i   (size_q),
        .rd_signed_i (signed_q),
        .rd_data_i   (prdata),
        .rd_data_o   (rd_data)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TmoLast);

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pdata_d     = pdata_q;
        pstb_d      = pstb_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        size_d      = size_q;
        signed_d    = signed_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    if (misaligned) begin
                        // Fault straight to RESP; the bus is never touched.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = SETUP;
                        psel_d   = 1'b1;
                        paddr_d  = req_addr;
                        pwrite_d = req_write;
                        size_d   = req_size;
                        signed_d = req_signed;
                        pstb_d   = req_write ? wr_strb : 4'h0;
                        pdata_d  = req_write ? wr_data : '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready || timeout_hit) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pready ? perr : 1'b1;
                    rsp_rdata_d = (!pready || perr || pwrite_q) ? '0 : rd_data;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pdata_q     <= '0;
            pstb_q      <= 4'h0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pdata_q     <= pdata_d;
            pstb_q      <= pstb_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign paddr     = paddr_q;
    assign pdata     = pdata_q;
    assign pstb      = pstb_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed scenarios plus randomized transfers checked
// against an arithmetic model of lane steering, extension, errors and latency.
module tb_apb_requester;
    import apb_pkg::*;

    localparam int TmoP = 8;

    logic        pclk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [31:0] prdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        pready;
    logic        perr;

    int n_cmp = 0;
    int n_err = 0;

    apb_requester #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TmoP)
    ) dut (
        .pclk      (pclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_write (req_write),
        .req_size  (req_size),
        .req_signed(req_signed),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pdata     (pdata),
        .prdata    (prdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pstb      (pstb),
        .pready    (pready),
        .perr      (perr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pick the addressed bytes out of the word, then extend as a number.
    function automatic logic [31:0] model_rd(input logic [31:0] prd, input int off, input int nb,
                                             input logic sg);
        longint v;
        longint span;
        logic [63:0] r;
        v    = longint'({32'd0, prd}) >> (8 * off);
        span = longint'(1) << (8 * nb);
        v    = v % span;
        if (sg && v >= span / 2) v = v - span;
        r = 64'(v);
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_pdata(input logic [31:0] wd, input int nb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nb) +: 8];
        return r;
    endfunction

    task automatic xfer(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] prd, input logic pe, input int waits,
                        input logic tie);
        int          nb, off, lat_exp, acc, lat;
        logic        mis, tmo, exp_err, psel_seen;
        logic [31:0] exp_rd;
        logic [3:0]  exp_stb;
        nb      = 1 << sz;
        off     = int'(addr[1:0]);
        mis     = (sz == 2'd3) || ((off % nb) != 0);
        tmo     = !mis && (waits >= TmoP);
        lat_exp = mis ? 1 : (tmo ? 2 + TmoP : 3 + waits);
        exp_err = mis || tmo || pe;
        exp_rd  = (exp_err || wr) ? 32'd0 : model_rd(prd, off, nb, sg);
        exp_stb = wr ? 4'(((1 << nb) - 1) << off) : 4'h0;

        @(negedge pclk);
        chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wd;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        prdata     = prd;
        perr       = pe;
        pready     = tie;
        lat        = 0;
        acc        = 0;
        psel_seen  = 1'b0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(negedge pclk);
            if (i == 1) begin
                // Scramble request fields to show they were latched at accept.
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_size  = 2'($urandom_range(0, 3));
                req_write = ~wr;
            end
            if (psel) psel_seen = 1'b1;
            if (rsp_valid) begin
                lat = i;
            end else begin
                if (!mis && i == 1) begin
                    chk({tag, "/setup_psel"}, 32'(psel), 32'd1);
                    chk({tag, "/setup_penable"}, 32'(penable), 32'd0);
                    chk({tag, "/paddr"}, paddr, addr);
                    chk({tag, "/pwrite"}, 32'(pwrite), 32'(wr));
                    chk({tag, "/pstb"}, 32'(pstb), 32'(exp_stb));
                    if (wr) chk({tag, "/pdata"}, pdata, model_pdata(wd, nb));
                end
                if (!mis && i == 2) chk({tag, "/access_penable"}, 32'(penable), 32'd1);
                if (psel && penable) begin
                    acc++;
                    pready = tie || (acc > waits);
                end else begin
                    pready = tie;
                end
            end
        end
        pready = 1'b0;
        perr   = 1'b0;
        chk({tag, "/latency"}, 32'(lat), 32'(lat_exp));
        if (lat != 0) begin
            chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, "/rsp_rdata"}, rsp_rdata, exp_rd);
            chk({tag, "/resp_ready"}, 32'(req_ready), 32'd0);
            chk({tag, "/resp_psel"}, 32'(psel), 32'd0);
        end
        if (mis) chk({tag, "/no_psel"}, 32'(psel_seen), 32'd0);
    endtask

    initial begin
        logic rv_seen;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_write  = 1'b0;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        prdata     = '0;
        pready     = 1'b0;
        perr       = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst/psel", 32'(psel), 32'd0);
        chk("rst/penable", 32'(penable), 32'd0);
        chk("rst/pwrite", 32'(pwrite), 32'd0);
        chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst/rsp_err", 32'(rsp_err), 32'd0);
        chk("rst/paddr", paddr, 32'd0);
        chk("rst/pdata", pdata, 32'd0);
        chk("rst/rsp_rdata", rsp_rdata, 32'd0);
        chk("rst/pstb", 32'(pstb), 32'd0);
        chk("rst/req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;

        xfer("t1_word_st", 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, SZ_WORD, 1'b0, 32'h0, 1'b0, 0, 1'b1);
        xfer("t2_sbyte_ld", 32'h8000_0003, 32'h0, 1'b0, SZ_BYTE, 1'b1, 32'h80FF_0000, 1'b0, 2, 1'b0);
        chk("t2_sbyte_ld/const", rsp_rdata, 32'hFFFF_FF80);
        xfer("t2_ubyte_ld", 32'h8000_0003, 32'h0, 1'b0, SZ_BYTE, 1'b0, 32'h80FF_0000, 1'b0, 2, 1'b0);
        chk("t2_ubyte_ld/const", rsp_rdata, 32'h0000_0080);
        xfer("t3_half_st", 32'h1000_0002, 32'h0000_1234, 1'b1, SZ_HALF, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        xfer("t3_half_mis", 32'h1000_0001, 32'h0, 1'b0, SZ_HALF, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        xfer("t3_size3", 32'h1000_0000, 32'h0, 1'b1, 2'd3, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        xfer("t4_perr", 32'h3000_0000, 32'h0, 1'b0, SZ_WORD, 1'b0, 32'h1234_5678, 1'b1, 0, 1'b0);
        xfer("t5_wait7", 32'h2000_0004, 32'h0, 1'b0, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0, 7, 1'b0);
        xfer("t5_tmo", 32'h2000_0008, 32'h0, 1'b0, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0, 50, 1'b0);
        xfer("t5_after", 32'h2000_0006, 32'h0, 1'b0, SZ_HALF, 1'b1, 32'h9ABC_0000, 1'b0, 1, 1'b0);

        // Reset in the middle of ACCESS abandons the transfer silently.
        @(negedge pclk);
        req_valid = 1'b1;
        req_addr  = 32'h4000_0000;
        req_write = 1'b0;
        req_size  = SZ_WORD;
        @(negedge pclk);
        req_valid = 1'b0;
        @(negedge pclk);
        chk("t6/access", 32'({psel, penable}), 32'd3);
        reset = 1'b1;
        @(negedge pclk);
        chk("t6/psel", 32'(psel), 32'd0);
        chk("t6/penable", 32'(penable), 32'd0);
        chk("t6/rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        rv_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (rsp_valid) rv_seen = 1'b1;
        end
        chk("t6/req_ready", 32'(req_ready), 32'd1);
        chk("t6/no_rsp", 32'(rv_seen), 32'd0);
        xfer("t6_after", 32'h4000_0001, 32'h0000_00A5, 1'b1, SZ_BYTE, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] sz;
            int         w;
            sz = 2'($urandom_range(0, 3));
            w  = ($urandom_range(0, 9) == 0) ? TmoP + 2 : int'($urandom_range(0, 3));
            xfer($sformatf("rnd%0d", k), $urandom, $urandom, 1'($urandom), sz, 1'($urandom),
                 $urandom, ($urandom_range(0, 7) == 0), w, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
